// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Grant states plus the read fill returned on a forced abort.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_INSTR,
    GRANT_DATA
  } MemArbState_t;

  localparam logic [15:0] TIMEOUT_FILL = 16'hffff;

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Grant watchdog: counts cycles spent in a grant.
// Raises expire on the TIMEOUT_CYCLES-th grant cycle.
module mem_arbiter_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  assign expire = active && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!active) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction and data master ports onto one memory bus.
// Data-priority with burst limit; MEM_ARBITER_TIMEOUT_EN adds a grant watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  input  logic [19:1] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        timeout_err
);

  if (MAX_DATA_BURST < 1 || MAX_DATA_BURST > 15) begin : g_bad_burst
    $error("MAX_DATA_BURST must be 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  localparam logic [3:0] MAXB = 4'(MAX_DATA_BURST);

  MemArbState_t state;
  MemArbState_t state_d;
  logic [3:0]   burst;
  logic         burst_full;
  logic         expire;
  logic         done;
  logic [15:0]  rd_data;

`ifdef MEM_ARBITER_TIMEOUT_EN
  mem_arbiter_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .active(state != IDLE),
    .expire(expire)
  );

  // A real ack in the expiry cycle wins over the forced abort.
  assign timeout_err = expire && !q_m_ack;
  assign rd_data     = timeout_err ? TIMEOUT_FILL : q_m_data_in;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
  assign rd_data     = q_m_data_in;
`endif

  assign done            = q_m_ack || expire;
  assign burst_full      = (burst == MAXB);
  assign q_m_access      = (state != IDLE);
  assign instr_m_data_in = rd_data;
  assign data_m_data_in  = rd_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d      = state;
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = '0;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          data_m_access && !(instr_m_access && burst_full):
            state_d = GRANT_DATA;
          instr_m_access && (!data_m_access || burst_full):
            state_d = GRANT_INSTR;
          default:
            state_d = IDLE;
        endcase
      end
      GRANT_INSTR: begin
        q_m_addr    = instr_m_addr;
        q_m_bytesel = 2'b11;
        instr_m_ack = done;
        if (done) state_d = IDLE;
      end
      GRANT_DATA: begin
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        data_m_ack   = done;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts data wins that overtook a waiting instruction fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst <= '0;
    end else if (state == IDLE) begin
      if (!instr_m_access || state_d == GRANT_INSTR) begin
        burst <= '0;
      end else if (state_d == GRANT_DATA && !burst_full) begin
        burst <= burst + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
// Define MEM_ARBITER_TIMEOUT_EN to exercise the watchdog path.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] instr_m_addr;
  logic [15:0] instr_m_data_in;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_ack;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_in;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MAX_DATA_BURST(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_m_addr   (instr_m_addr),
    .instr_m_data_in(instr_m_data_in),
    .instr_m_access (instr_m_access),
    .instr_m_ack    (instr_m_ack),
    .data_m_addr    (data_m_addr),
    .data_m_data_in (data_m_data_in),
    .data_m_data_out(data_m_data_out),
    .data_m_access  (data_m_access),
    .data_m_ack     (data_m_ack),
    .data_m_wr_en   (data_m_wr_en),
    .data_m_bytesel (data_m_bytesel),
    .q_m_addr       (q_m_addr),
    .q_m_data_in    (q_m_data_in),
    .q_m_data_out   (q_m_data_out),
    .q_m_access     (q_m_access),
    .q_m_ack        (q_m_ack),
    .q_m_wr_en      (q_m_wr_en),
    .q_m_bytesel    (q_m_bytesel),
    .timeout_err    (timeout_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs may be driven right after, checks after settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset           = 1'b0;
    instr_m_addr    = '0;
    instr_m_access  = 1'b0;
    data_m_addr     = '0;
    data_m_data_out = '0;
    data_m_access   = 1'b0;
    data_m_wr_en    = 1'b0;
    data_m_bytesel  = '0;
    q_m_data_in     = '0;
    q_m_ack         = 1'b0;

    tick();
    settle();
    check("rst_access", q_m_access, 0);
    check("rst_addr", q_m_addr, 0);
    check("rst_bytesel", q_m_bytesel, 0);
    check("rst_wr", q_m_wr_en, 0);
    check("rst_acks", {instr_m_ack, data_m_ack, timeout_err}, 0);
    #2 reset = 1'b1;

    // Instruction-only read, ack two cycles after access.
    tick();
    instr_m_addr   = 19'h00010;
    instr_m_access = 1'b1;
    settle();
    check("i_pre_idle", q_m_access, 0);
    tick();
    settle();
    check("i_access", q_m_access, 1);
    check("i_addr", q_m_addr, 19'h00010);
    check("i_bytesel", q_m_bytesel, 2'b11);
    check("i_wr", q_m_wr_en, 0);
    check("i_noack", instr_m_ack, 0);
    tick();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'h1234;
    settle();
    check("i_ack", instr_m_ack, 1);
    check("i_data", instr_m_data_in, 16'h1234);
    check("i_dack", data_m_ack, 0);
    tick();
    q_m_ack        = 1'b0;
    instr_m_access = 1'b0;
    settle();
    check("i_bubble", q_m_access, 0);
    check("i_ack_gone", instr_m_ack, 0);

    // Simultaneous requests: data write first, bubble, then instr.
    tick();
    instr_m_access  = 1'b1;
    data_m_access   = 1'b1;
    data_m_addr     = 19'h00200;
    data_m_wr_en    = 1'b1;
    data_m_data_out = 16'hbeef;
    data_m_bytesel  = 2'b01;
    tick();
    settle();
    check("b_addr_d", q_m_addr, 19'h00200);
    check("b_wr", q_m_wr_en, 1);
    check("b_bytesel", q_m_bytesel, 2'b01);
    check("b_wdata", q_m_data_out, 16'hbeef);
    q_m_ack = 1'b1;
    settle();
    check("b_dack", {instr_m_ack, data_m_ack}, 2'b01);
    tick();
    q_m_ack       = 1'b0;
    data_m_access = 1'b0;
    data_m_wr_en  = 1'b0;
    settle();
    check("b_bubble", q_m_access, 0);
    tick();
    settle();
    check("b_addr_i", q_m_addr, 19'h00010);
    check("b_bytesel_i", q_m_bytesel, 2'b11);
    check("b_wdata_i", q_m_data_out, 0);
    q_m_ack = 1'b1;
    settle();
    check("b_iack", {instr_m_ack, data_m_ack}, 2'b10);
    tick();
    q_m_ack        = 1'b0;
    instr_m_access = 1'b0;
    tick();

    // Continuous contention: 4 data grants, 1 instr grant, then data again.
    instr_m_access = 1'b1;
    data_m_access  = 1'b1;
    q_m_ack        = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      settle();
      if (k % 2 == 0) begin
        check($sformatf("burst_g%0d", k / 2), q_m_addr,
              (k / 2 == 4) ? 19'h00010 : 19'h00200);
        check($sformatf("burst_ack%0d", k / 2),
              {instr_m_ack, data_m_ack},
              (k / 2 == 4) ? 2'b10 : 2'b01);
      end else begin
        check($sformatf("burst_gap%0d", k / 2), q_m_access, 0);
      end
    end
    instr_m_access = 1'b0;
    data_m_access  = 1'b0;
    q_m_ack        = 1'b0;
    tick();

    // Ack in first grant cycle; access falls after ack, no re-grant.
    data_m_access = 1'b1;
    tick();
    q_m_ack = 1'b1;
    settle();
    check("f_ack", data_m_ack, 1);
    tick();
    data_m_access = 1'b0;
    settle();
    check("f_bubble", q_m_access, 0);
    check("f_idle_ack", {instr_m_ack, data_m_ack}, 0);
    tick();
    q_m_ack = 1'b0;
    settle();
    check("f_no_dup", q_m_access, 0);

    // Asynchronous reset mid data grant.
    data_m_access = 1'b1;
    tick();
    settle();
    check("r_granted", q_m_access, 1);
    reset = 1'b0;
    settle();
    check("r_async", q_m_access, 0);
    data_m_access = 1'b0;
    #1 reset = 1'b1;
    tick();
    tick();
    settle();
    check("r_idle", q_m_access, 0);

`ifdef MEM_ARBITER_TIMEOUT_EN
    // Memory never acks: forced abort on the 8th grant cycle.
    q_m_data_in   = 16'h5555;
    data_m_access = 1'b1;
    tick();
    for (int c = 1; c < 8; c++) begin
      settle();
      check($sformatf("t_wait%0d", c), {data_m_ack, timeout_err}, 0);
      tick();
    end
    settle();
    check("t_ack", data_m_ack, 1);
    check("t_fill", data_m_data_in, 16'hffff);
    check("t_err", timeout_err, 1);
    check("t_iack", instr_m_ack, 0);
    tick();
    data_m_access = 1'b0;
    settle();
    check("t_idle", {q_m_access, timeout_err}, 0);
    tick();

    // Real ack in the expiry cycle wins.
    data_m_access = 1'b1;
    tick();
    for (int c = 1; c < 8; c++) tick();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'h4321;
    settle();
    check("t2_ack", data_m_ack, 1);
    check("t2_data", data_m_data_in, 16'h4321);
    check("t2_noerr", timeout_err, 0);
    tick();
    q_m_ack       = 1'b0;
    data_m_access = 1'b0;
    settle();
    check("t2_idle", q_m_access, 0);
`else
    // Without the watchdog a grant waits indefinitely.
    data_m_access = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) tick();
    settle();
    check("n_still", q_m_access, 1);
    check("n_noerr", {data_m_ack, timeout_err}, 0);
    q_m_ack     = 1'b1;
    q_m_data_in = 16'h4321;
    settle();
    check("n_ack", data_m_ack, 1);
    check("n_data", data_m_data_in, 16'h4321);
    tick();
    q_m_ack       = 1'b0;
    data_m_access = 1'b0;
    settle();
    check("n_idle", q_m_access, 0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sits directly downstream of the CPU core and merges its two master ports, the instruction (prefetch) bus and the data (load/store) bus, onto one external memory bus.
- Arbitrates with data priority, plus an anti-starvation limit for instruction fetches.
- Holds the grant until the memory acks.
- Routes read data and ack back to the granted requester only.

Parameters:
MAX_DATA_BURST, 4, consecutive data grants allowed while an instruction request is pending before instruction wins (1..15)
TIMEOUT_CYCLES, 255, cycles without ack before a forced abort (only with MEM_ARBITER_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
instr_m_addr  in  19  instruction word address [19:1]
instr_m_data_in  out  16  read data to instruction master
instr_m_access  in  1  instruction request, held until ack
instr_m_ack  out  1  one-cycle completion to instruction master
data_m_addr  in  19  data word address [19:1]
data_m_data_in  out  16  read data to data master
data_m_data_out  in  16  write data from data master
data_m_access  in  1  data request, held until ack
data_m_ack  out  1  one-cycle completion to data master
data_m_wr_en  in  1  data write enable
data_m_bytesel  in  2  data byte lanes
q_m_addr  out  19  memory word address
q_m_data_in  in  16  memory read data
q_m_data_out  out  16  memory write data
q_m_access  out  1  memory request
q_m_ack  in  1  memory completion
q_m_wr_en  out  1  memory write enable
q_m_bytesel  out  2  memory byte lanes
timeout_err  out  1  one-cycle pulse on forced abort

Behaviour:
- States: IDLE, GRANT_INSTR, GRANT_DATA. State is registered; q_m_access = (state != IDLE).
- Reset (reset low, asynchronous): state IDLE, burst counter 0, timeout counter 0. Outputs q_m_access/q_m_wr_en/instr_m_ack/data_m_ack/timeout_err = 0, q_m_bytesel = 0, addresses and data = 0.
- IDLE decision from the current-cycle access inputs:
  - data only -> GRANT_DATA.
  - instr only -> GRANT_INSTR.
  - both -> GRANT_DATA, unless burst counter == MAX_DATA_BURST, in which case GRANT_INSTR.
  - none -> stay in IDLE.
- Burst counter:
  - increments on each entry to GRANT_DATA while instr_m_access is high, saturating at MAX_DATA_BURST.
  - clears on entry to GRANT_INSTR, or in any IDLE cycle with instr_m_access low.
- Grant muxing, combinational from state:
  - GRANT_DATA: q_m_addr/data_out/wr_en/bytesel = data master fields.
  - GRANT_INSTR: q_m_addr = instr_m_addr, wr_en 0, bytesel 2'b11, data_out 0.
  - IDLE: all 0.
- Ack routing: the granted master's ack = q_m_ack, combinational, same cycle; the other ack = 0.
  - instr_m_data_in and data_m_data_in both carry q_m_data_in; masters qualify it with their own ack.
- On q_m_ack the next state is IDLE. The mandatory bubble cycle stops a master that is still asserting access in its ack cycle from being re-granted.
- Latency: request at cycle N -> q_m_access at N+1 -> earliest ack at N+1 -> next grant at N+3.
- q_m_ack while in IDLE is ignored; no ack is forwarded.
- Requests must stay stable while granted. A master dropping access mid-grant is illegal; the arbiter keeps the grant until ack.
- Reset mid-grant: returns to IDLE immediately; any outstanding memory cycle is abandoned.

Optional Feature:
MEM_ARBITER_TIMEOUT_EN
- Defined:
  - A counter runs while state != IDLE and clears on IDLE.
  - If it reaches TIMEOUT_CYCLES without q_m_ack, the arbiter forces an ack to the granted master that cycle, with read data 16'hffff.
  - timeout_err pulses for 1 cycle and state returns to IDLE.
  - A q_m_ack arriving in that same cycle takes precedence: normal completion, no error.
- Undefined: no counter; a grant waits for ack indefinitely; timeout_err tied 0.

Decomposition:
- Shared package: state enum (MemArbState_t: IDLE, GRANT_INSTR, GRANT_DATA) and the timeout fill constant 16'hffff.
- No sub-module is required. The optional timeout counter may be a small mem_arbiter_timeout module, instantiated under the macro.

Test Plan:
- Instr only, addr 19'h00010, memory acks 2 cycles after access, data 16'h1234 -> q_m_addr 19'h00010, bytesel 11, instr_m_ack for 1 cycle with data 16'h1234, data_m_ack stays 0.
- Simultaneous instr and data requests from IDLE, data write 16'hbeef, bytesel 01 -> data granted first (q_m_wr_en 1, bytesel 01), then a bubble, then the instr grant.
- Data requests continuously with instr pending, MAX_DATA_BURST=4 -> exactly 4 data grants, then 1 instr grant, then the counter restarts.
- Ack in the first grant cycle with access still high in that cycle -> q_m_access drops for one IDLE cycle; no duplicate grant when access falls after ack.
- Assert reset low mid GRANT_DATA -> q_m_access 0 asynchronously; after release with no requests, stays IDLE.
- MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never acks -> forced data_m_ack with 16'hffff and timeout_err pulse 8 cycles after grant; with an ack on cycle 8 -> no error.
